// File: rtl/piso_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_arbiter: round-robin two-source parallel-to-serial controller.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module piso_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             sout,
  output logic             svalid,
  output logic             sfirst,
  output logic             slast,
  output logic             grant,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;

  logic             any_req;
  logic             winner;
  logic             at_final;
  logic             capture_ok;

  assign any_req    = req0 | req1;
  // On a tie the requester that did not win last time goes first.
  assign winner     = (req0 && req1) ? ~last_grant_q : req1;
  assign at_final   = (state_q == SHIFT) && (cnt_q == LAST);
  assign capture_ok = (state_q == IDLE) || at_final;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    if (flush) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (capture_ok && any_req) begin
      state_d      = SHIFT;
      shreg_d      = winner ? data1 : data0;
      cnt_d        = '0;
      grant_d      = winner;
      last_grant_d = winner;
      ack0_d       = ~winner;
      ack1_d       = winner;
    end else if (at_final) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign svalid = busy;
  assign sout   = busy & shreg_q[WIDTH-1];
  assign sfirst = busy && (cnt_q == '0);
  assign slast  = busy && (cnt_q == LAST);
  assign grant  = grant_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_piso_arbiter: directed self-checking bench for piso_arbiter.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_piso_arbiter;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       flush = 1'b0;
  logic       req0 = 1'b0;
  logic [5:0] data0 = '0;
  logic       ack0;
  logic       req1 = 1'b0;
  logic [5:0] data1 = '0;
  logic       ack1;
  logic       sout, svalid, sfirst, slast, grant, busy;

  int n_assert = 0;
  int n_fail   = 0;

  piso_arbiter #(.WIDTH(6)) dut (
    .clk    (clk),
    .clear  (clear),
    .flush  (flush),
    .req0   (req0),
    .data0  (data0),
    .ack0   (ack0),
    .req1   (req1),
    .data1  (data1),
    .ack1   (ack1),
    .sout   (sout),
    .svalid (svalid),
    .sfirst (sfirst),
    .slast  (slast),
    .grant  (grant),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Packed view: {ack0, ack1, grant, busy, svalid, sfirst, slast, sout}
  function automatic logic [7:0] obs_vec();
    return {ack0, ack1, grant, busy, svalid, sfirst, slast, sout};
  endfunction

  function automatic logic [7:0] word_vec(input logic who, input logic [5:0] d, input int k);
    logic [7:0] v;
    v[7] = (k == 0) && !who;
    v[6] = (k == 0) && who;
    v[5] = who;
    v[4] = 1'b1;
    v[3] = 1'b1;
    v[2] = (k == 0);
    v[1] = (k == 5);
    v[0] = d[5-k];
    return v;
  endfunction

  function automatic logic [7:0] idle_vec(input logic g);
    return {2'b00, g, 5'b00000};
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = obs_vec();
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full word starting at the next edge; after the ack cycle the
  // requests in drop_mask ({req1,req0}) are lowered and the source's data updated.
  task automatic run_word(input string tag, input logic who, input logic [5:0] d,
                          input logic [1:0] drop_mask, input logic [5:0] nd);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("%s_k%0d", tag, k), word_vec(who, d, k));
      if (k == 0) begin
        if (who) data1 = nd; else data0 = nd;
        if (drop_mask[0]) req0 = 1'b0;
        if (drop_mask[1]) req1 = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    step();
    clear = 1'b1;
  endtask

  initial begin
    // Reset state, checked asynchronously before any clock edge.
    #1;
    chk("reset", 8'h00);
    step();
    clear = 1'b1;

    // Single word from requester 0.
    req0 = 1'b1; data0 = 6'b111010;
    run_word("t1", 1'b0, 6'b111010, 2'b01, 6'b111010);
    step();
    chk("t1_idle", idle_vec(1'b0));

    // Both held: alternating grants, no gaps.
    do_reset();
    req0 = 1'b1; data0 = 6'b101101;
    req1 = 1'b1; data1 = 6'b011100;
    run_word("t2a", 1'b0, 6'b101101, 2'b00, 6'b101101);
    run_word("t2b", 1'b1, 6'b011100, 2'b00, 6'b011100);
    run_word("t2c", 1'b0, 6'b101101, 2'b00, 6'b101101);
    run_word("t2d", 1'b1, 6'b011100, 2'b11, 6'b011100);
    step();
    chk("t2_idle", idle_vec(1'b1));

    // Back-to-back words from requester 1 alone.
    req1 = 1'b1; data1 = 6'b110011;
    run_word("t3a", 1'b1, 6'b110011, 2'b00, 6'b000001);
    run_word("t3b", 1'b1, 6'b000001, 2'b10, 6'b000001);
    step();
    chk("t3_idle", idle_vec(1'b1));

    // Flush on shift cycle 3 while req1 waits.
    req0 = 1'b1; data0 = 6'b111111;
    step();
    chk("t4_k0", word_vec(1'b0, 6'b111111, 0));
    req0 = 1'b0;
    req1 = 1'b1; data1 = 6'b101010;
    step();
    chk("t4_k1", word_vec(1'b0, 6'b111111, 1));
    step();
    chk("t4_k2", word_vec(1'b0, 6'b111111, 2));
    flush = 1'b1;
    step();
    chk("t4_flush", idle_vec(1'b0));
    flush = 1'b0;
    step();
    chk("t4_req1", word_vec(1'b1, 6'b101010, 0));
    req1 = 1'b0;
    flush = 1'b1;
    step();
    chk("t4_flush_mid", idle_vec(1'b1));
    // Flush beats a request arriving in IDLE.
    req0 = 1'b1; data0 = 6'b110110;
    step();
    chk("t4_flush_idle", idle_vec(1'b1));
    flush = 1'b0;
    step();
    chk("t5_k0", word_vec(1'b0, 6'b110110, 0));
    req0 = 1'b0;
    step();
    chk("t5_k1", word_vec(1'b0, 6'b110110, 1));
    step();
    chk("t5_k2", word_vec(1'b0, 6'b110110, 2));

    // Asynchronous clear mid-word, then a tie after release.
    clear = 1'b0;
    #1;
    chk("t5_clear", 8'h00);
    req0 = 1'b1; data0 = 6'b100110;
    req1 = 1'b1; data1 = 6'b011001;
    step();
    chk("t5_held", 8'h00);
    clear = 1'b1;
    run_word("t5a", 1'b0, 6'b100110, 2'b01, 6'b100110);
    run_word("t5b", 1'b1, 6'b011001, 2'b10, 6'b011001);
    step();
    chk("t5_idle", idle_vec(1'b1));

    // req0 withdrawn mid-word: never captured.
    req1 = 1'b1; data1 = 6'b100000;
    step();
    chk("t6_k0", word_vec(1'b1, 6'b100000, 0));
    req1 = 1'b0;
    step();
    chk("t6_k1", word_vec(1'b1, 6'b100000, 1));
    req0 = 1'b1; data0 = 6'b111111;
    step();
    chk("t6_k2", word_vec(1'b1, 6'b100000, 2));
    req0 = 1'b0;
    for (int k = 3; k < 6; k++) begin
      step();
      chk($sformatf("t6_k%0d", k), word_vec(1'b1, 6'b100000, k));
    end
    step();
    chk("t6_idle", idle_vec(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
